frame_buffer_arbiter: RTL



---
 rtl/fba_pkg.sv | 13 +
 rtl/fba_wr_fifo.sv | 53 +++++
 rtl/frame_buffer_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fba_pkg.sv
// Shared types and default widths for the frame buffer arbiter.
package fba_pkg;

  localparam int FBA_ADDR_W = 16;
  localparam int FBA_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FROZEN  = 2'd2
  } cap_state_t;

endpackage

// File: rtl/fba_wr_fifo.sv
// Small synchronous FIFO holding {addr,data} capture pixels; a push while full
// is accepted when a pop happens in the same cycle.
module fba_wr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_en;
  logic             pop_en;

  // DEPTH is a power of two, so the count MSB alone marks full.
  assign empty   = (count_reg == '0);
  assign full    = count_reg[PTR_W];
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign dout    = mem_q[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Shares one single-port frame memory between camera capture writes and VGA
// reads; define FBA_STATS_EN to add drop_cnt/frame_cnt statistics outputs.
module frame_buffer_arbiter
  import fba_pkg::*;
#(
  parameter int ADDR_W       = FBA_ADDR_W,
  parameter int DATA_W       = FBA_DATA_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int RD_BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              wr_sof,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              frozen,
  output logic              overflow
`ifdef FBA_STATS_EN
  ,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int BW = $clog2(RD_BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_LIMIT = BW'(RD_BURST_MAX);

  cap_state_t               state_reg;
  logic                     frozen_reg;
  logic                     overflow_reg;
  logic [BW-1:0]            burst_reg;
  logic                     rd_pend_reg;
  logic                     rd_valid_reg;
  logic [DATA_W-1:0]        rd_data_reg;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     write_turn;
  logic                     capturing;
  logic                     wr_drop;
  logic [ADDR_W+DATA_W-1:0] fifo_dout;

  fba_wr_fifo #(
    .WIDTH(ADDR_W + DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_wr_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  ({wr_addr, wr_data}),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Reads win except when the burst budget is spent with pixels waiting.
  assign write_turn = !fifo_empty && (burst_reg == BURST_LIMIT);
  assign rd_gnt     = rst_n && rd_req && !write_turn;
  assign fifo_pop   = rst_n && !fifo_empty && !rd_gnt;
  assign capturing  = (state_reg == CAPTURE);
  assign fifo_push  = capturing && wr_valid && (!fifo_full || fifo_pop);
  assign wr_drop    = capturing && wr_valid && fifo_full && !fifo_pop;

  assign mem_en    = rd_gnt || fifo_pop;
  assign mem_we    = fifo_pop;
  assign mem_addr  = rd_gnt ? rd_addr : fifo_dout[ADDR_W+DATA_W-1:DATA_W];
  assign mem_wdata = fifo_dout[DATA_W-1:0];

  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign frozen   = frozen_reg;
  assign overflow = overflow_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      frozen_reg <= 1'b0;
    end else if (wr_sof) begin
      case (state_reg)
        IDLE: begin
          state_reg  <= freeze ? FROZEN : CAPTURE;
          frozen_reg <= freeze;
        end
        CAPTURE: begin
          if (freeze) begin
            state_reg  <= FROZEN;
            frozen_reg <= 1'b1;
          end
        end
        FROZEN: begin
          if (!freeze) begin
            state_reg  <= CAPTURE;
            frozen_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= IDLE;
          frozen_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_reg    <= '0;
      rd_pend_reg  <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (rd_gnt && !fifo_empty)      burst_reg <= burst_reg + 1'b1;
      else if (fifo_pop || fifo_empty) burst_reg <= '0;
      // Memory answers one cycle after the grant; register it once more.
      rd_pend_reg  <= rd_gnt;
      rd_valid_reg <= rd_pend_reg;
      if (rd_pend_reg) rd_data_reg <= mem_rdata;
      if (wr_drop) overflow_reg <= 1'b1;
    end
  end

`ifdef FBA_STATS_EN
  logic [15:0] drop_cnt_reg;
  logic [15:0] frame_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_reg  <= '0;
      frame_cnt_reg <= '0;
    end else begin
      if (wr_drop && (drop_cnt_reg != 16'hFFFF)) drop_cnt_reg <= drop_cnt_reg + 1'b1;
      if (wr_sof && !freeze) frame_cnt_reg <= frame_cnt_reg + 1'b1;
    end
  end

  assign drop_cnt  = drop_cnt_reg;
  assign frame_cnt = frame_cnt_reg;
`endif

endmodule
